ch_event_arbiter: RTL and testbench
===================================

# ch_event_arbiter

Converts the 12 synchronized `synchro_CH` lines into single-cycle-accepted events for the game logic. Each rising edge is held as a pending request. A round-robin arbiter then issues one channel index at a time over a valid/ready handshake. The block sits between the 25 MHz input synchronizer and the target/score logic. Every encoder step and trigger is delivered exactly once, or else flagged as overrun.

## Interface
- `N_CH`, 12, number of input channels.
- `IDX_W`, 4, width of the channel index (ceil(log2(N_CH))).

- `clk25` in 1: 25 MHz system clock. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `synchro_CH` in N_CH: channel levels, already synchronized to `clk25`.
- `ev_valid` out 1: an event is offered on `ev_idx`.
- `ev_idx` out IDX_W: channel number of the offered event, 0..N_CH-1.
- `ev_ready` in 1: consumer accepts the event on a cycle where `ev_valid` and `ev_ready` are both 1.
- `pending` out N_CH: per-channel request latched and not yet loaded for offer.
- `overrun` out N_CH: sticky flag; a rising edge arrived while that channel was already pending.
- `clr_overrun` in 1: synchronous clear of all `overrun` bits.

## Operation
- Edge detect:
  - `prev` register samples `synchro_CH` every cycle.
  - `rise[i] = synchro_CH[i] & ~prev[i]`.
  - `prev` resets to all-ones, so lines held high through reset release produce no event.
- Pending:
  - `pending[i]` sets on `rise[i]`.
  - `pending[i]` clears on the cycle channel i is loaded into the output register.
  - If `rise[i]` and the load of channel i occur in the same cycle, `pending[i]` stays 1 (new event) and `overrun[i]` is not set.
- Overrun:
  - `overrun[i]` sets when `rise[i]` occurs while `pending[i]` is 1 and is not being loaded that cycle.
  - `clr_overrun` clears all bits; a set in the same cycle wins.
- Arbitration: round-robin pointer `ptr` (0..N_CH-1, reset 0).
  - The search runs from `ptr` upward and wraps from N_CH-1 to 0.
  - The first pending channel found is selected.
  - After a load of channel j, `ptr` becomes j+1 mod N_CH.
- FSM states:
  - IDLE:
    - `ev_valid`=0.
    - If any `pending`, load the selected index into `ev_idx`, set `ev_valid`, and go to OFFER.
  - OFFER:
    - `ev_valid`=1, and `ev_idx` is held stable while `ev_ready`=0.
    - On `ev_ready`=1, if any `pending` (excluding nothing), load the next selected index and stay in OFFER (back-to-back).
    - On `ev_ready`=1 with no `pending`, go to IDLE and drop `ev_valid`.
- A channel being offered may pend again at the same time; it is re-offered only after its turn in the rotation.
- `ev_idx` never exceeds N_CH-1.

## Timing
- Reset values:
  - `ev_valid`=0, `ev_idx`=0.
  - `pending`=0, `overrun`=0.
  - `ptr`=0, FSM=IDLE, `prev`=all-ones.
- Reset is asynchronous: asserting `rst` mid-offer drops `ev_valid` immediately and discards all pending events.
- Latency: `synchro_CH[i]` is high for the first time at edge k.
  - `pending[i]`=1 after edge k.
  - `ev_valid`=1 with `ev_idx`=i after edge k+1, if the output was idle.
- Throughput: one event per cycle while `ev_ready` is held 1 and requests remain.
- Handshake: the consumer may hold `ev_ready` high permanently. `ev_valid` does not depend combinationally on `ev_ready`.

## Test plan
- Single edge:
  - Stimulus: `synchro_CH`=0x000 → 0x004 at edge 10, `ev_ready`=1.
  - Response: `pending[2]` after edge 10; `ev_valid`=1 with `ev_idx`=2 for exactly one cycle after edge 11; `overrun`=0.
- Simultaneous requests with round-robin:
  - Stimulus: 0x000 → 0x821 in one cycle, `ev_ready`=1.
  - Response: `ev_idx` sequence 0, 5, 11 on consecutive cycles.
  - Follow-up: a later rise on bits 0 and 5 gives sequence 0, 5, because `ptr` wrapped to 0.
- Backpressure:
  - Stimulus: rise on channel 7, `ev_ready`=0 for 20 cycles.
  - Response: `ev_valid`=1 and `ev_idx`=7 stable for 20 cycles; one accept on ready; then `ev_valid`=0.
- Overrun:
  - Stimulus: with `ev_ready`=0 and channel 3 offered, pulse channel 4 high/low twice.
  - Response: `overrun[4]`=1 and one event for channel 4.
  - Then: `clr_overrun` for one cycle gives `overrun`=0.
  - Same-cycle check: `clr_overrun` coinciding with a new overrun leaves the bit at 1.
- Reset behaviour:
  - Stimulus: hold `synchro_CH`=0xFFF across `rst` release.
  - Response: no events.
  - Stimulus: assert `rst` during OFFER.
  - Response: `ev_valid` falls before the next clock edge, and `pending`=0 after reset.
- Reload edge case:
  - Stimulus: `rise[6]` on the same cycle channel 6 is loaded.
  - Response: `pending[6]` stays 1, no overrun, and channel 6 is offered a second time.

Source files
------------

// File: rtl/ch_event_arbiter.sv
// ch_event_arbiter: turns rising edges on synchronized channel lines into
// pending requests, then offers them one at a time, round-robin, over a
// valid/ready handshake. A rise on a channel that is still pending is
// reported through a sticky overrun flag.
module ch_event_arbiter #(
  parameter int N_CH  = 12,
  parameter int IDX_W = 4
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic [N_CH-1:0]  synchro_CH,
  output logic             ev_valid,
  output logic [IDX_W-1:0] ev_idx,
  input  logic             ev_ready,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overrun,
  input  logic             clr_overrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  prev_q, prev_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ev_idx_q, ev_idx_d;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  load_mask;
  logic             load;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // Channel index base+off, wrapped into 0..N_CH-1 (off is always < N_CH).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return IDX_W'(s);
  endfunction

  // Edge detection against the previous sample of the channel lines.
  always_comb begin
    prev_d = synchro_CH;
    rise   = synchro_CH & ~prev_q;
  end

  // Round-robin search: first pending channel at or after ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!sel_found && pending_q[wrap_add(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Handshake FSM: decides when the selected channel is loaded for offer.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (ev_ready) begin
          if (sel_found) load = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register, rotation pointer, pending and overrun bookkeeping.
  always_comb begin
    load_mask = '0;
    if (load) load_mask[sel_idx] = 1'b1;

    ev_idx_d = load ? sel_idx : ev_idx_q;
    ptr_d    = load ? wrap_add(sel_idx, 1) : ptr_q;

    // A rise on the cycle the channel is loaded re-arms it as a new event.
    pending_d = (pending_q & ~load_mask) | rise;

    // A set in the same cycle as the clear wins.
    overrun_d = (clr_overrun ? '0 : overrun_q) | (rise & pending_q & ~load_mask);
  end

  // State registers; prev resets high so lines already high give no event.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '1;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      ev_idx_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      ev_idx_q  <= ev_idx_d;
    end
  end

  // Valid comes straight from the state flop, never from ev_ready.
  always_comb begin
    ev_valid = (state_q == ST_OFFER);
    ev_idx   = ev_idx_q;
    pending  = pending_q;
    overrun  = overrun_q;
  end

endmodule

// File: tb/tb_ch_event_arbiter.sv
// Scoreboard bench for ch_event_arbiter: stimulus pushes expected channel
// indices; a negedge monitor pops and compares on every accepted event.
module tb_ch_event_arbiter;

  localparam int N_CH  = 12;
  localparam int IDX_W = 4;

  logic             clk25 = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  synchro_CH;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_ready;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  overrun;
  logic             clr_overrun;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  ch_event_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) dut (
    .clk25      (clk25),
    .rst        (rst),
    .synchro_CH (synchro_CH),
    .ev_valid   (ev_valid),
    .ev_idx     (ev_idx),
    .ev_ready   (ev_ready),
    .pending    (pending),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_reset(input logic [N_CH-1:0] ch);
    rst         = 1'b1;
    synchro_CH  = ch;
    ev_ready    = 1'b0;
    clr_overrun = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk25);
    #1 rst = 1'b0;
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk25) begin
    if (!rst && ev_valid) begin
      check("idx_range", 32'(ev_idx < IDX_W'(N_CH)), 32'd1);
      if (ev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(ev_idx), 32'hFFFF_FFFF);
        end else begin
          check("event_idx", 32'(ev_idx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    do_reset('0);
    check("rst_valid",   32'(ev_valid), 32'd0);
    check("rst_idx",     32'(ev_idx),   32'd0);
    check("rst_pending", 32'(pending),  32'd0);
    check("rst_overrun", 32'(overrun),  32'd0);

    // Single edge on channel 2.
    ev_ready = 1'b1;
    tick();
    synchro_CH = 12'h004; exp_q.push_back(2);
    tick();
    check("single_pending", 32'(pending), 32'h004);
    check("single_valid0",  32'(ev_valid), 32'd0);
    tick();
    check("single_valid1",  32'(ev_valid), 32'd1);
    check("single_idx",     32'(ev_idx),   32'd2);
    check("single_pclr",    32'(pending),  32'h000);
    tick();
    check("single_valid2",  32'(ev_valid), 32'd0);
    check("single_overrun", 32'(overrun),  32'd0);

    // Simultaneous requests, then wrap of the pointer back to 0.
    do_reset('0);
    ev_ready = 1'b1;
    tick();
    synchro_CH = 12'h821;
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(11);
    tick();
    check("rr_pending", 32'(pending), 32'h821);
    tick(); check("rr_idx0",  32'(ev_idx), 32'd0);
    tick(); check("rr_idx5",  32'(ev_idx), 32'd5);
    tick(); check("rr_idx11", 32'(ev_idx), 32'd11);
    tick(); check("rr_idle",  32'(ev_valid), 32'd0);
    synchro_CH = 12'h000;
    tick();
    synchro_CH = 12'h021; exp_q.push_back(0); exp_q.push_back(5);
    tick();
    tick(); check("wrap_idx0", 32'(ev_idx), 32'd0);
    tick(); check("wrap_idx5", 32'(ev_idx), 32'd5);
    tick(); check("wrap_idle", 32'(ev_valid), 32'd0);

    // Backpressure on channel 7.
    do_reset('0);
    tick();
    synchro_CH = 12'h080; exp_q.push_back(7);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {31'd0, ev_valid} | (32'(ev_idx) << 4), 32'h71);
      if (i < 19) tick();
    end
    ev_ready = 1'b1;
    tick();
    check("bp_release", 32'(ev_valid), 32'd0);

    // Overrun on channel 4 while channel 3 is offered.
    do_reset('0);
    tick();
    synchro_CH = 12'h008; exp_q.push_back(3);
    tick(); tick();
    check("ovr_offer3", 32'(ev_idx), 32'd3);
    synchro_CH = 12'h018; tick();
    synchro_CH = 12'h008; tick();
    synchro_CH = 12'h018; tick();
    synchro_CH = 12'h008; tick();
    check("ovr_set",     32'(overrun), 32'h010);
    check("ovr_pending", 32'(pending), 32'h010);
    exp_q.push_back(4);
    ev_ready = 1'b1;
    tick(); check("ovr_idx4",  32'(ev_idx),   32'd4);
    tick(); check("ovr_idle",  32'(ev_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'h010);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("ovr_clear", 32'(overrun), 32'h000);
    // Clear coinciding with a new overrun: the set wins.
    ev_ready = 1'b0;
    synchro_CH = 12'h018; exp_q.push_back(4); tick();
    synchro_CH = 12'h008; tick();
    synchro_CH = 12'h018; tick();
    synchro_CH = 12'h008; tick();
    synchro_CH = 12'h018; clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'h010);
    exp_q.push_back(4);
    ev_ready = 1'b1;
    tick(); tick();
    check("ovr2_idle", 32'(ev_valid), 32'd0);

    // Lines held high across reset release produce nothing.
    do_reset(12'hFFF);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_high_valid", 32'(ev_valid), 32'd0);
    end
    check("rst_high_pending", 32'(pending), 32'd0);

    // Asynchronous reset during an offer.
    ev_ready = 1'b0;
    synchro_CH = 12'h000; tick();
    synchro_CH = 12'h003; tick(); tick();
    check("arst_offer", 32'(ev_valid), 32'd1);
    #5 rst = 1'b1;
    #1;
    check("arst_valid_drop", 32'(ev_valid), 32'd0);
    check("arst_pending",    32'(pending),  32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk25);
    #1 rst = 1'b0;
    ev_ready = 1'b1;
    tick(); tick();
    check("arst_after_valid",   32'(ev_valid), 32'd0);
    check("arst_after_pending", 32'(pending),  32'd0);

    // Rise on channel 6 on the same cycle it is loaded.
    do_reset('0);
    tick();
    synchro_CH = 12'h020; exp_q.push_back(5); tick();
    tick();
    synchro_CH = 12'h060; tick();
    synchro_CH = 12'h020; tick();
    check("reload_pre_pending", 32'(pending), 32'h040);
    ev_ready = 1'b1;
    synchro_CH = 12'h060; exp_q.push_back(6); exp_q.push_back(6);
    tick();
    check("reload_idx",     32'(ev_idx),  32'd6);
    check("reload_pending", 32'(pending), 32'h040);
    check("reload_overrun", 32'(overrun), 32'h000);
    tick();
    check("reload_idx2",    32'(ev_idx),   32'd6);
    check("reload_valid2",  32'(ev_valid), 32'd1);
    tick();
    check("reload_idle",    32'(ev_valid), 32'd0);

    // Drain with a bound, then every expected event must have been seen.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
